// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment text scanner: the glyph
// table, the special character codes and the segment bit positions.
package ssd_pkg;

    // Character codes with a fixed meaning on the display.
    localparam logic [7:0] CURSOR_CODE = 8'h5D;
    localparam logic [7:0] BLANK_CODE  = 8'h00;

    // Segment bit positions inside a 7-bit pattern (a is the MSB).
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Buffer event chosen this cycle after strobe priority has been resolved.
    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_CLEAR = 2'd1,
        EV_BKSP  = 2'd2,
        EV_CHAR  = 2'd3
    } event_e;

    // Make code -> active-high abcdefg pattern; unknown codes are blank.
    function automatic logic [6:0] glyph_of(input logic [7:0] code);
        case (code)
            8'h1C:   glyph_of = 7'h77; // A
            8'h24:   glyph_of = 7'h4F; // E
            8'h43:   glyph_of = 7'h30; // I
            8'h44:   glyph_of = 7'h7E; // O
            8'h3C:   glyph_of = 7'h3E; // U
            8'h32:   glyph_of = 7'h1F; // b
            8'h21:   glyph_of = 7'h4E; // C
            8'h23:   glyph_of = 7'h3D; // d
            8'h2B:   glyph_of = 7'h47; // F
            8'h34:   glyph_of = 7'h5F; // G
            8'h33:   glyph_of = 7'h37; // H
            8'h4B:   glyph_of = 7'h0E; // L
            8'h31:   glyph_of = 7'h15; // n
            8'h4D:   glyph_of = 7'h67; // p
            8'h2D:   glyph_of = 7'h05; // r
            8'h1B:   glyph_of = 7'h5B; // S
            8'h2C:   glyph_of = 7'h0F; // t
            8'h5D:   glyph_of = 7'h06; // cursor
            default: glyph_of = 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/ssd_glyph_rom.sv
// Combinational character-code to active-high segment pattern lookup.
module ssd_glyph_rom
    import ssd_pkg::*;
(
    input  logic [7:0] code,
    output logic [6:0] pattern
);

    // Pure table lookup; the scan path registers the result downstream.
    assign pattern = glyph_of(code);

endmodule

// File: rtl/ssd_text_scanner.sv
// Text buffer with write cursor, multiplexed onto a common-anode
// seven-segment display with a blinking cursor digit.
module ssd_text_scanner
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000,
    parameter bit WRAP        = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          char_valid,
    input  logic [7:0]                    char_code,
    input  logic                          backspace,
    input  logic                          clear,
    output logic [6:0]                    seg_n,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] cursor_pos
);

    localparam int CW = $clog2(NUM_DIGITS);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_DIGITS - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLNK_LAST = BW'(BLINK_DIV - 1);

    logic [7:0]            buf_q [NUM_DIGITS];
    logic [7:0]            buf_d [NUM_DIGITS];
    logic [CW-1:0]         cursor_q, cursor_d;
    logic [CW-1:0]         scan_q, scan_d;
    logic [RW-1:0]         refresh_q, refresh_d;
    logic [BW-1:0]         blink_q, blink_d;
    logic                  phase_q, phase_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    event_e                ev;
    logic [7:0]            disp_code;
    logic [6:0]            glyph;

    // Resolve strobe priority; a backspace at cursor 0 swallows lower strobes.
    always_comb begin
        ev = EV_NONE;
        if (clear) begin
            ev = EV_CLEAR;
        end else if (backspace) begin
            ev = (cursor_q != '0) ? EV_BKSP : EV_NONE;
        end else if (char_valid) begin
            ev = EV_CHAR;
        end
    end

    // Buffer and cursor next state.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        buf_d    = buf_q;
        cursor_d = cursor_q;
        case (ev)
            EV_CLEAR: begin
                for (int i = 0; i < NUM_DIGITS; i++) buf_d[i] = BLANK_CODE;
                cursor_d = '0;
            end
            EV_BKSP: begin
                buf_d[cursor_q - CW'(1)] = BLANK_CODE;
                cursor_d                 = cursor_q - CW'(1);
            end
            EV_CHAR: begin
                buf_d[cursor_q] = char_code;
                if (cursor_q != LAST_IDX) cursor_d = cursor_q + CW'(1);
                else if (WRAP)            cursor_d = '0;
                else                      cursor_d = LAST_IDX;
            end
            default: ;
        endcase
    end

    // Refresh divider, scan index and cursor blink timing.
    always_comb begin
        refresh_d = refresh_q + RW'(1);
        scan_d    = scan_q;
        if (refresh_q == REF_LAST) begin
            refresh_d = '0;
            scan_d    = (scan_q == LAST_IDX) ? '0 : scan_q + CW'(1);
        end

        blink_d = blink_q + BW'(1);
        phase_d = phase_q;
        if (ev != EV_NONE) begin
            blink_d = '0;
            phase_d = 1'b1;
        end else if (blink_q == BLNK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end
    end

    // Pick the character for the scanned digit, overlaying the cursor glyph.
    always_comb begin
        disp_code = buf_q[scan_q];
        if (scan_q == cursor_q && phase_q) disp_code = CURSOR_CODE;
        an_d         = '1;
        an_d[scan_q] = 1'b0;
        seg_d        = ~glyph;
    end

    ssd_glyph_rom u_glyph_rom (
        .code    (disp_code),
        .pattern (glyph)
    );

    // All state, including the text buffer, with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the text buffer is reset too, since a blank display after reset is visible behaviour.
            for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= BLANK_CODE;
            cursor_q  <= '0;
            scan_q    <= '0;
            refresh_q <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
            seg_q     <= 7'h7F;
            an_q      <= '1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= buf_d[i];
            cursor_q  <= cursor_d;
            scan_q    <= scan_d;
            refresh_q <= refresh_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg_n      = seg_q;
    assign an_n       = an_q;
    assign cursor_pos = cursor_q;

endmodule

// File: doc/ssd_text_scanner.md
Name: ssd_text_scanner

Overview:
Multi-digit seven-segment text display with cursor. It accepts PS/2 make-code characters into a NUM_DIGITS-entry text buffer at a write cursor, and supports backspace and clear. It time-multiplexes the buffer onto a common-anode display: one active-low anode at a time, with active-low segments. The cursor digit blinks between the stored character and the cursor glyph. It sits between the keyboard scan-code receiver and the board's seven-segment pins.

Parameters:
NUM_DIGITS, 4, number of display digits and buffer entries (2..8)
REFRESH_DIV, 100000, clk cycles each digit is lit per scan step (>=2)
BLINK_DIV, 25000000, clk cycles per cursor blink half-period (>=2)
WRAP, 1, 1 = cursor wraps from NUM_DIGITS-1 to 0 after a write; 0 = cursor saturates at NUM_DIGITS-1 (later writes overwrite the last digit)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
char_valid  in  1  single-cycle strobe: char_code is a new character
char_code  in  8  PS/2 make code
backspace  in  1  single-cycle strobe: delete the character before the cursor
clear  in  1  single-cycle strobe: blank the buffer and home the cursor
seg_n  out  7  active-low segments, bit6=a .. bit0=g
an_n  out  NUM_DIGITS  active-low anodes; an_n[i] lights buffer entry i
cursor_pos  out  $clog2(NUM_DIGITS)  current write cursor index

Behaviour:
- Reset state (async, rst_n=0):
  - buffer entries = 8'h00 (blank); cursor_pos=0
  - scan_idx=0; refresh and blink counters=0; blink_phase=0
  - seg_n=7'h7F; an_n=all ones
- Event priority in one cycle: clear > backspace > char_valid. Only the highest strobe is acted on.
- clear: all entries <= 8'h00; cursor <= 0.
- backspace:
  - cursor>0: entry[cursor-1] <= 8'h00; cursor <= cursor-1.
  - cursor==0: no-op, and it does not count as an accepted event.
- char_valid: entry[cursor] <= char_code.
  - cursor<NUM_DIGITS-1: cursor <= cursor+1.
  - cursor==NUM_DIGITS-1 and WRAP=1: cursor <= 0.
  - cursor==NUM_DIGITS-1 and WRAP=0: cursor stays at NUM_DIGITS-1.
- Accepted event (clear, char_valid, or backspace that moves the cursor): blink counter <= 0 and blink_phase <= 1, so the cursor is shown immediately.
- Refresh counter counts 0..REFRESH_DIV-1. At terminal count it returns to 0 and scan_idx advances modulo NUM_DIGITS.
- Blink counter counts 0..BLINK_DIV-1. At terminal count blink_phase toggles. An accepted event takes precedence over the toggle.
- Output register, updated every cycle from current state (1-cycle latency):
  - an_n <= ~(1<<scan_idx)
  - display code = (scan_idx==cursor && blink_phase) ? 8'h5D : entry[scan_idx]
  - seg_n <= ~glyph(display code)
  - A buffer write appears on seg_n one cycle after the write edge if that digit is being scanned.
- Glyph table, active-high abcdefg (hex): 1C A 77; 24 E 4F; 43 I 30; 44 O 7E; 3C U 3E; 32 b 1F; 21 C 4E; 23 d 3D; 2B F 47; 34 G 5F; 33 H 37; 4B L 0E; 31 n 15; 4D p 67; 2D r 05; 1B S 5B; 2C t 0F; 5D cursor 06. Every other code is blank (00).
- Reset asserted mid-scan or mid-blink: immediate return to reset state; no partial outputs.
- Exactly one an_n bit is low on every cycle after the first post-reset edge.

Decomposition:
- Package ssd_pkg:
  - glyph table as a constant function/case (code -> 7-bit pattern)
  - CURSOR_CODE=8'h5D, BLANK_CODE=8'h00
  - segment bit-order constants
- One sub-module ssd_glyph_rom: combinational code-to-pattern lookup, instantiated once on the scan path.
- Counters, buffer and cursor logic stay in the top.

Test Plan:
Bench parameters for all cases: NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=16, WRAP=1 unless stated.
1. Release reset and observe 16 cycles -> an_n steps 1110, 1101, 1011, 0111 every 4 cycles. Digit 0 shows seg_n=~06 while blink_phase=1 and 7F when 0. Other digits show 7F.
2. Write codes 1C, 24, 43 -> cursor_pos=3. Digits 0..2 show ~77, ~4F, ~30. Digit 3 alternates ~06 / 7F every 16 cycles.
3. Write a 4th code 44, then 5th code 3C -> after the 4th write cursor_pos=0 (wrap). The 5th write overwrites digit 0 with ~3E and cursor_pos=1. With WRAP=0, the 5th write lands in digit 3 and cursor_pos stays 3.
4. Backspace at cursor_pos=2 -> entry1 blank, cursor_pos=1. Backspace at cursor_pos=0 -> no change; blink phase is not reset.
5. Assert clear, backspace and char_valid(1C) in the same cycle -> all digits blank, cursor_pos=0, no 1C stored.
6. Pulse rst_n low for 1 cycle mid-scan, asynchronous to clk -> outputs go to 7F / all-ones immediately. Buffer is blank and the scan restarts at digit 0.
